range_coalesce: RTL

- Stage directly downstream of merge_phase.
- Once the final merge pass has left the bank holding tuples sorted ascending by lo, this block streams the sorted (lo,hi) inclusive ranges out of the bank as even/odd pairs.
- Merges overlapping and adjacent ranges into disjoint ranges.
- Reports the total count of IDs covered and the number of disjoint ranges.

---
 rtl/range_coalesce.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/range_coalesce.sv
// range_coalesce: streams sorted (lo,hi) ranges from the bank as even/odd pairs and merges them into disjoint ranges.
// Latency 2*ceil(count/2)+3 cycles start->done; no backpressure. Optional writeback: RANGE_COALESCE_WRITEBACK_EN.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 8
`endif

module range_coalesce #(
    parameter int VAL_WIDTH   = 64,
    parameter int TOTAL_WIDTH = 72,
    parameter int WB_BASE     = 0
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start_in,
    input  logic [`BANK_ADDR_WIDTH:0]    count_in,
    output logic [`BANK_ADDR_WIDTH-1:0]  read_addr_out,
    output logic                         read_en_out,
    input  logic [2*VAL_WIDTH-1:0]       even_data_in,
    input  logic [2*VAL_WIDTH-1:0]       odd_data_in,
    output logic [`BANK_ADDR_WIDTH-1:0]  write_addr_out,
    output logic                         write_en_out,
    output logic [2*VAL_WIDTH-1:0]       even_data_out,
    output logic [2*VAL_WIDTH-1:0]       odd_data_out,
    output logic [TOTAL_WIDTH-1:0]       total_out,
    output logic [`BANK_ADDR_WIDTH:0]    range_count_out,
    output logic                         busy_out,
    output logic                         done_out
);
    localparam int BA = `BANK_ADDR_WIDTH;

    typedef struct packed {
        logic [VAL_WIDTH-1:0] lo;
        logic [VAL_WIDTH-1:0] hi;
    } tuple_pair_t;

    typedef enum logic [2:0] {IDLE, READ, EVEN, ODD, FLUSH, DONE} state_t;

    state_t              state_q, state_d;
    logic [BA:0]         count_q;
    logic [BA-1:0]       ptr_q, ptr_d;
    tuple_pair_t         odd_q, cur_q, cur_d, proc_t;
    logic                cur_vld_q, cur_vld_d;
    logic [TOTAL_WIDTH-1:0] total_q;
    logic [BA:0]         rcnt_q;
    logic                emit, proc_en, skip, accept;
    logic [BA+1:0]       two_p, cnt_ext;
    logic [VAL_WIDTH:0]  hi_p1, span;

    assign accept  = (state_q == IDLE) && start_in;
    assign two_p   = {1'b0, ptr_q, 1'b0};
    assign cnt_ext = {1'b0, count_q};
    assign proc_t  = (state_q == EVEN) ? tuple_pair_t'(even_data_in) : odd_q;
    assign proc_en = (state_q == EVEN) ||
                     ((state_q == ODD) && ((two_p + (BA+2)'(1)) < cnt_ext));
    assign skip    = (proc_t == '1) || (proc_t.lo > proc_t.hi);
    // Extra bit keeps hi = max from wrapping in the adjacency test and the span.
    assign hi_p1   = {1'b0, cur_q.hi} + (VAL_WIDTH+1)'(1);
    assign span    = {1'b0, cur_q.hi} - {1'b0, cur_q.lo} + (VAL_WIDTH+1)'(1);

    always_comb begin
        cur_d     = cur_q;
        cur_vld_d = cur_vld_q;
        emit      = 1'b0;
        if (proc_en && !skip) begin
            if (!cur_vld_q) begin
                cur_d     = proc_t;
                cur_vld_d = 1'b1;
            end else if ({1'b0, proc_t.lo} <= hi_p1) begin
                if (proc_t.hi > cur_q.hi) cur_d.hi = proc_t.hi;
            end else begin
                emit  = 1'b1;
                cur_d = proc_t;
            end
        end
        if (state_q == FLUSH) begin
            emit      = cur_vld_q;
            cur_vld_d = 1'b0;
        end
    end

    // An empty pass spends its first cycle in READ without strobing the bank,
    // which keeps start->done at 2*ceil(count/2)+3 for every count.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        read_en_out   = 1'b0;
        read_addr_out = '0;
        case (state_q)
            IDLE:  if (start_in) state_d = READ;
            READ: begin
                read_en_out   = (count_q != '0);
                read_addr_out = ptr_q;
                state_d       = (count_q != '0) ? EVEN : FLUSH;
            end
            EVEN:  state_d = ODD;
            ODD: begin
                if ((two_p + (BA+2)'(2)) < cnt_ext) begin
                    read_en_out   = 1'b1;
                    read_addr_out = ptr_q + BA'(1);
                    ptr_d         = ptr_q + BA'(1);
                    state_d       = EVEN;
                end else begin
                    state_d = FLUSH;
                end
            end
            FLUSH: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            ptr_q     <= '0;
            odd_q     <= '0;
            cur_q     <= '0;
            cur_vld_q <= 1'b0;
            total_q   <= '0;
            rcnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == EVEN) odd_q <= tuple_pair_t'(odd_data_in);
            if (accept) begin
                count_q   <= count_in;
                ptr_q     <= '0;
                cur_vld_q <= 1'b0;
                total_q   <= '0;
                rcnt_q    <= '0;
            end else begin
                ptr_q     <= ptr_d;
                cur_q     <= cur_d;
                cur_vld_q <= cur_vld_d;
                if (emit) begin
                    total_q <= total_q + {{(TOTAL_WIDTH-VAL_WIDTH-1){1'b0}}, span};
                    rcnt_q  <= rcnt_q + (BA+1)'(1);
                end
            end
        end
    end

    assign total_out       = total_q;
    assign range_count_out = rcnt_q;
    assign busy_out        = (state_q != IDLE) && (state_q != DONE);
    assign done_out        = (state_q == DONE);

`ifdef RANGE_COALESCE_WRITEBACK_EN
    tuple_pair_t          wb_even_q, wb_e, wb_o;
    logic                 wb_half_q, wb_go;
    logic [BA-1:0]        wb_ptr_q, wr_addr_q;
    logic                 wr_en_q;
    logic [2*VAL_WIDTH-1:0] wr_even_q, wr_odd_q;

    // A pair goes out when its odd slot fills, or at flush with the odd slot padded.
    always_comb begin
        wb_go = 1'b0;
        wb_e  = wb_even_q;
        wb_o  = cur_q;
        if (emit) begin
            if (wb_half_q) begin
                wb_go = 1'b1;
            end else if (state_q == FLUSH) begin
                wb_go = 1'b1;
                wb_e  = cur_q;
                wb_o  = '1;
            end
        end else if ((state_q == FLUSH) && wb_half_q) begin
            wb_go = 1'b1;
            wb_o  = '1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_even_q <= '0;
            wb_half_q <= 1'b0;
            wb_ptr_q  <= BA'(WB_BASE);
            wr_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_even_q <= '0;
            wr_odd_q  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (accept) begin
                wb_half_q <= 1'b0;
                wb_ptr_q  <= BA'(WB_BASE);
            end else if (wb_go) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= wb_ptr_q;
                wr_even_q <= wb_e;
                wr_odd_q  <= wb_o;
                wb_ptr_q  <= wb_ptr_q + BA'(1);
                wb_half_q <= 1'b0;
            end else if (emit) begin
                wb_even_q <= cur_q;
                wb_half_q <= 1'b1;
            end
        end
    end

    assign write_en_out   = wr_en_q;
    assign write_addr_out = wr_addr_q;
    assign even_data_out  = wr_even_q;
    assign odd_data_out   = wr_odd_q;
`else
    logic unused_wb_base;
    assign unused_wb_base = (WB_BASE < 0);
    assign write_en_out   = 1'b0;
    assign write_addr_out = '0;
    assign even_data_out  = '0;
    assign odd_data_out   = '0;
`endif

endmodule
